// File: rtl/input_key_encoder_pkg.sv
// Shared key-encoder definitions: key geometry, repeat-FSM encoding, bitmap helpers.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package input_key_encoder_pkg;

  localparam int KEY_W = 4;   // bits in a key code
  localparam int KEY_N = 16;  // keys in the scanner bitmap

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rep_state_e;

  // Number of keys currently down.
  function automatic logic [$clog2(KEY_N):0] key_count(input logic [KEY_N-1:0] v);
    logic [$clog2(KEY_N):0] c;
    c = '0;
    for (int i = 0; i < KEY_N; i++) c = c + ($clog2(KEY_N)+1)'(v[i]);
    return c;
  endfunction

  // Index of the lowest set bit; only meaningful when exactly one bit is set.
  function automatic logic [KEY_W-1:0] key_index(input logic [KEY_N-1:0] v);
    logic [KEY_W-1:0] idx;
    idx = '0;
    for (int i = KEY_N-1; i >= 0; i--) if (v[i]) idx = KEY_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/input_key_encoder_if.sv
// Scanner-side key bitmap in, consumer-side key events out, plus overflow status.
// Latency: none (bundle of wires).
// Backpressure: key_ready from the consumer side stalls the event head.
// Ports: key_state/rep_en/key_ready/ovf_clr toward the encoder; key_code/key_valid/overflow from it.
interface input_key_encoder_if;
  import input_key_encoder_pkg::*;

  logic [KEY_N-1:0] key_state;
  logic             rep_en;
  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_ready;
  logic             overflow;
  logic             ovf_clr;

  // master: the encoder, which sources key events
  modport master (
    input  key_state, rep_en, key_ready, ovf_clr,
    output key_code, key_valid, overflow
  );

  // slave: scanner + command decoder environment
  modport slave (
    output key_state, rep_en, key_ready, ovf_clr,
    input  key_code, key_valid, overflow
  );

endinterface

// File: rtl/input_key_encoder_key_fifo.sv
// DEPTH x W event FIFO with a registered head view (dout / empty).
// Latency: a push becomes visible on dout/~empty after the following edge (no bypass).
// Backpressure: push is taken when not full or when a pop happens the same cycle.
// Ports: clk, rst_n, push/din in, pop in, dout/empty (registered head view), full (combinational).
module input_key_encoder_key_fifo
  import input_key_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = KEY_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("key fifo DEPTH must be a power of two and at least 2");
  end

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic [AW:0]   count;
  logic          wr;

  assign full    = (count == (AW+1)'(DEPTH));
  assign wr      = push & (~full | pop);
  assign rd_next = pop ? rd_ptr + 1'b1 : rd_ptr;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= din;
  end

  // The head view looks at the FIFO after this cycle's pop but before this
  // cycle's push, so a pop never re-presents the entry just consumed and a
  // fresh push shows up one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      empty  <= 1'b1;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_next;
      count  <= count + (AW+1)'(wr) - (AW+1)'(pop);
      empty  <= ((count - (AW+1)'(pop)) == '0);
      dout   <= mem[rd_next];
    end
  end

endmodule

// File: rtl/input_key_encoder.sv
// Turns the debounced key bitmap into single-key press / typematic repeat events.
// Latency: press sampled at edge n is pushed at edge n and shows on key_valid after edge n+1.
// Backpressure: events queue in a DEPTH FIFO; a push to a full FIFO with no pop is dropped and sets overflow.
// Ports: clk, rst_n (async active-low), bus (master modport: key_state/rep_en/key_ready/ovf_clr in,
//        key_code/key_valid/overflow out).
module input_key_encoder
  import input_key_encoder_pkg::*;
#(
  parameter int DELAY = 5_000_000,
  parameter int RATE  = 1_000_000,
  parameter int CW    = 24,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input_key_encoder_if.master bus
);

  localparam longint unsigned MAX_DR = (DELAY > RATE) ? DELAY : RATE;

  if ((64'd1 << CW) <= MAX_DR) begin : g_cw_chk
    $error("CW too narrow to count up to max(DELAY, RATE)");
  end
  if (DELAY < 2 || RATE < 2) begin : g_time_chk
    $error("DELAY and RATE must both be at least 2");
  end

  rep_state_e       state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx, cnt_inc;
  logic [KEY_W-1:0] code_q, code_nx;
  logic [KEY_N-1:0] prev;
  logic             changed, press;
  logic             push;
  logic [KEY_W-1:0] push_code;
  logic             pop, full, empty, drop;
  logic [KEY_W-1:0] head_code;
  logic             overflow_q;

  assign changed = (bus.key_state != prev);
  assign press   = (|(bus.key_state & ~prev)) &&
                   (key_count(bus.key_state) == ($clog2(KEY_N)+1)'(1));
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    code_nx   = code_q;
    push      = 1'b0;
    push_code = code_q;
    if (press) begin
      push      = 1'b1;
      push_code = key_index(bus.key_state);
      code_nx   = push_code;
      cnt_nx    = '0;
      state_nx  = HOLD;
    end else if (changed) begin
      // any other bitmap change (chord, partial or full release) cancels repeat
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        HOLD: begin
          if (!bus.rep_en) begin
            cnt_nx = '0;
          end else if (cnt == CW'(DELAY - 1)) begin
            push     = 1'b1;
            cnt_nx   = '0;
            state_nx = REPEAT;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
        REPEAT: begin
          if (!bus.rep_en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else if (cnt == CW'(RATE - 1)) begin
            push   = 1'b1;
            cnt_nx = '0;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      code_q <= '0;
      prev   <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      code_q <= code_nx;
      prev   <= bus.key_state;
    end
  end

  assign pop  = ~empty & bus.key_ready;
  assign drop = push & full & ~pop;

  // a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            overflow_q <= 1'b0;
    else if (drop)         overflow_q <= 1'b1;
    else if (bus.ovf_clr)  overflow_q <= 1'b0;
  end

  input_key_encoder_key_fifo #(
    .DEPTH (DEPTH),
    .W     (KEY_W)
  ) u_key_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_code),
    .pop   (pop),
    .dout  (head_code),
    .empty (empty),
    .full  (full)
  );

  assign bus.key_code  = head_code;
  assign bus.key_valid = ~empty;
  assign bus.overflow  = overflow_q;

endmodule
